sa_out_collector: RTL and testbench
===================================

// Module: sa_out_collector
// PURPOSE
//  Read side of the systolic array output port. Sequences channel_out_reset/channel_out_en, captures
//  the 16 per-row result words the array presents, and unpacks them by mode (8x8 or 1x8).
//  Accumulates them over ci_tiles input-channel tiles, then drains the rows on a valid/ready stream.
// PARAMETERS
//  ROW_NUM        16  array rows = rows captured per tile = rows drained
//  COLUMN_NUM     16  array columns
//  PIXEL_WIDTH_88 24  lane width, mode 0 (2 lanes per column)
//  PIXEL_WIDTH_18 16  lane width, mode 1 (4 lanes per column)
//  ACC_WIDTH      32  accumulator/output lane width, signed
//  CI_TILE_W       8  width of ci_tiles
// PORTS
//  clk                in   1                     clock
//  reset              in   1                     synchronous, active-low (0 = reset)
//  start              in   1                     1-cycle job start; honoured only in IDLE
//  mode               in   1                     0 = 8x8 lanes, 1 = 1x8 lanes; latched on start
//  ci_tiles           in   CI_TILE_W             tiles to accumulate; 0 treated as 1; latched on start
//  sa_done            in   1                     array finished current tile, results stable
//  channel_out_reset  out  1                     clears the array row counter
//  channel_out_en     out  1                     array presents row k on the k-th asserted cycle
//  sa_out             in   16*2*2*COLUMN_NUM     array row word (1024 b at defaults)
//  busy               out  1                     high in any state except IDLE
//  done               out  1                     1-cycle pulse after the last drain beat
//  m_valid            out  1                     drain beat valid
//  m_ready            in   1                     downstream ready
//  m_row              out  clog2(ROW_NUM)        row index of current beat
//  m_data             out  64*ACC_WIDTH          lane p at [p*ACC_WIDTH +: ACC_WIDTH]
// BEHAVIOUR
//  - Reset (reset==0): state IDLE; channel_out_reset=1; channel_out_en, busy, done, m_valid = 0;
//    m_row, m_data, tile/row counters = 0. Reset mid-job aborts; accumulator contents are don't-care.
//  - IDLE: on start, latch mode/ci_tiles, pulse channel_out_reset for 1 cycle, tile_cnt=0 -> WAIT_SA.
//  - WAIT_SA: channel_out_en=0; on sa_done -> CAPTURE next cycle.
//  - CAPTURE: channel_out_en=1 for exactly ROW_NUM cycles. sa_out is combinational from the array
//    row counter, so row k is sampled on the k-th CAPTURE cycle (zero latency) into acc[k].
//    Unpack mode 0: lane p = sext(sa_out[p*24 +: 24]), p=0..31; lanes 32..63 are 0.
//    Unpack mode 1: lane p = sext(sa_out[p*16 +: 16]), p=0..63.
//    If tile_cnt==0, acc[k] = lanes; else acc[k] += lanes (two's-complement wrap mod 2^ACC_WIDTH).
//    After row ROW_NUM-1: if tile_cnt==ci_tiles_eff-1 -> DRAIN, else tile_cnt++ -> WAIT_SA.
//    The array counter wraps to 0 on its own; no further channel_out_reset is needed between tiles.
//  - DRAIN: m_valid=1, m_row=r, m_data=acc[r]. The beat advances only on m_valid&&m_ready. The
//    payload is held stable while stalled. After beat r=ROW_NUM-1 -> DONE.
//  - DONE: done=1 for one cycle -> IDLE; start in the same cycle is ignored.
//  - sa_done outside WAIT_SA is ignored. start while busy is ignored. mode/ci_tiles are only
//    sampled at start.
//  - Latency, ci_tiles=1, m_ready=1: start -> channel_out_reset +1 cycle; sa_done -> first
//    channel_out_en +1; last capture -> first m_valid +1; last beat -> done +1.
// CONFIGURATION
//  SA_COLLECT_RELU_EN defined: in DRAIN, each m_data lane with MSB=1 is driven as 0.
//    The accumulator itself is not modified.
//  SA_COLLECT_RELU_EN undefined: m_data is the raw signed accumulator.
// TESTING
//  1 mode0, ci_tiles=1, each row k: all lanes 24'hFFFFFF (-1) + k -> drain row k lanes 0..31 = k-1,
//    lanes 32..63 = 0; 16 beats; done one cycle after beat 15.
//  2 mode1, ci_tiles=3, every lane 16'h0005 each tile -> every lane = 15;
//    exactly 48 channel_out_en cycles.
//  3 mode1, ci_tiles=0 -> behaves as 1 tile: 16 channel_out_en cycles, then drain.
//  4 Drain with m_ready toggled 1,0,0,1,...: no beat lost or duplicated; m_row 0..15 in order;
//    m_data stable while m_ready=0.
//  5 reset=0 for 1 cycle mid-CAPTURE (row 7) -> next cycle IDLE, channel_out_en=0, m_valid=0;
//    a new start completes a clean job with correct results.
//  6 RELU_EN: lane accumulates to -3 -> output 0; lane accumulates to +3 -> output 3.
//    Without RELU_EN, the -3 lane reads 32'hFFFFFFFD.

Source files
------------

// File: rtl/sa_out_collector_if.sv
// Drain-side stream of the systolic array output collector.
// One beat carries one accumulated row: row index plus all lanes packed LSB-first.
interface sa_out_collector_if #(
  parameter int ROW_NUM   = 16,
  parameter int LANES     = 64,
  parameter int ACC_WIDTH = 32
);
  localparam int ROW_W = $clog2(ROW_NUM);

  logic                       m_valid;
  logic                       m_ready;
  logic [ROW_W-1:0]           m_row;
  logic [LANES*ACC_WIDTH-1:0] m_data;

  modport master (
    output m_valid,
    output m_row,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_row,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/sa_out_collector.sv
// Read side of the systolic array output port.
// Sequences channel_out_reset/channel_out_en, captures ROW_NUM row words per tile,
// unpacks them by mode (0: 24-bit lanes, 1: 16-bit lanes), accumulates across
// ci_tiles input-channel tiles and drains the rows on a valid/ready stream.
// Optional feature macro: SA_COLLECT_RELU_EN (negative output lanes driven as 0;
// the stored accumulator is left untouched).
module sa_out_collector #(
  parameter int ROW_NUM        = 16,
  parameter int COLUMN_NUM     = 16,
  parameter int PIXEL_WIDTH_88 = 24,
  parameter int PIXEL_WIDTH_18 = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int CI_TILE_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          mode,
  input  logic [CI_TILE_W-1:0]          ci_tiles,
  input  logic                          sa_done,
  output logic                          channel_out_reset,
  output logic                          channel_out_en,
  input  logic [16*2*2*COLUMN_NUM-1:0]  sa_out,
  output logic                          busy,
  output logic                          done,
  sa_out_collector_if.master            m_if
);

  localparam int LANES  = 4 * COLUMN_NUM;
  localparam int LANES0 = 2 * COLUMN_NUM;
  localparam int ROW_W  = $clog2(ROW_NUM);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SA,
    CAPTURE,
    DRAIN,
    DONE_S
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic                   mode_q;
  logic [CI_TILE_W-1:0]   tile_last_q;
  logic [CI_TILE_W-1:0]   tile_cnt;
  logic [ROW_W-1:0]       row_cnt;
  logic                   row_last;
  logic                   tile_last;
  logic                   m_valid;

  logic [ACC_WIDTH-1:0]   acc   [ROW_NUM][LANES];
  logic [ACC_WIDTH-1:0]   lanes [LANES];
  logic [ACC_WIDTH-1:0]   lane_v;
  logic [LANES*ACC_WIDTH-1:0] m_data_d;

  assign row_last  = (row_cnt == ROW_W'(ROW_NUM - 1));
  assign tile_last = (tile_cnt == tile_last_q);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_nxt      = state;
    channel_out_en = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    m_valid        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = WAIT_SA;
      end
      WAIT_SA: begin
        if (sa_done) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        channel_out_en = 1'b1;
        if (row_last) state_nxt = tile_last ? DRAIN : WAIT_SA;
      end
      DRAIN: begin
        m_valid = 1'b1;
        if (m_if.m_ready && row_last) state_nxt = DONE_S;
      end
      DONE_S: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job parameters, array-counter reset pulse, tile and row counters.
  // The last tile index (ci_tiles-1, with 0 treated as 1) is stored instead of
  // the tile count so the end-of-job test is a plain equality.
  always_ff @(posedge clk) begin
    if (!reset) begin
      channel_out_reset <= 1'b1;
      mode_q            <= 1'b0;
      tile_last_q       <= '0;
      tile_cnt          <= '0;
      row_cnt           <= '0;
    end else begin
      channel_out_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            channel_out_reset <= 1'b1;
            mode_q            <= mode;
            tile_last_q       <= (ci_tiles == '0) ? '0 : ci_tiles - 1'b1;
            tile_cnt          <= '0;
            row_cnt           <= '0;
          end
        end
        CAPTURE: begin
          if (row_last) begin
            row_cnt <= '0;
            if (!tile_last) tile_cnt <= tile_cnt + 1'b1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (m_if.m_ready) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Unpack the presented row word into sign-extended lanes for the latched mode
  always_comb begin
    for (int unsigned p = 0; p < LANES; p++) begin
      lanes[p] = mode_q ? ACC_WIDTH'($signed(sa_out[p*PIXEL_WIDTH_18 +: PIXEL_WIDTH_18])) : '0;
    end
    for (int unsigned p = 0; p < LANES0; p++) begin
      if (!mode_q) lanes[p] = ACC_WIDTH'($signed(sa_out[p*PIXEL_WIDTH_88 +: PIXEL_WIDTH_88]));
    end
  end

  // Accumulate the current row: first tile overwrites, later tiles add with wrap
  always_ff @(posedge clk) begin
    if (reset && state == CAPTURE) begin
      for (int unsigned p = 0; p < LANES; p++) begin
        acc[row_cnt][p] <= (tile_cnt == '0) ? lanes[p] : acc[row_cnt][p] + lanes[p];
      end
    end
  end

  // Drain payload: the addressed accumulator row, held while the beat is stalled
  always_comb begin
    m_data_d = '0;
    lane_v   = '0;
    if (state == DRAIN) begin
      for (int unsigned p = 0; p < LANES; p++) begin
        lane_v = acc[row_cnt][p];
`ifdef SA_COLLECT_RELU_EN
        if (lane_v[ACC_WIDTH-1]) lane_v = '0;
`endif
        m_data_d[p*ACC_WIDTH +: ACC_WIDTH] = lane_v;
      end
    end
  end

  assign m_if.m_valid = m_valid;
  assign m_if.m_row   = (state == DRAIN) ? row_cnt : '0;
  assign m_if.m_data  = m_data_d;

endmodule

// File: tb/tb_sa_out_collector.sv
// Self-checking bench for sa_out_collector: emulates the array row counter,
// keeps a per-job expected accumulator computed from tile data by plain
// summation, and checks every drain beat, handshake timing and control pulses.
module tb_sa_out_collector;
  localparam int ROWS  = 16;
  localparam int LANES = 64;
  localparam int AW    = 32;
  localparam int MAXT  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         sa_done = 1'b0;
  logic [7:0]   ci_tiles = '0;
  logic         channel_out_reset;
  logic         channel_out_en;
  logic         busy;
  logic         done;
  logic [1023:0] sa_out;

  sa_out_collector_if #(.ROW_NUM(ROWS), .LANES(LANES), .ACC_WIDTH(AW)) bus ();

  sa_out_collector #(
    .ROW_NUM(ROWS), .COLUMN_NUM(16), .PIXEL_WIDTH_88(24),
    .PIXEL_WIDTH_18(16), .ACC_WIDTH(AW), .CI_TILE_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ci_tiles(ci_tiles),
    .sa_done(sa_done), .channel_out_reset(channel_out_reset),
    .channel_out_en(channel_out_en), .sa_out(sa_out), .busy(busy), .done(done),
    .m_if(bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tile data the emulated array presents, and the expected accumulated rows
  logic [1023:0] tdata [MAXT][ROWS];
  logic [31:0]   expv  [ROWS][LANES];

  // Emulated array: row counter cleared by channel_out_reset, advanced per enable
  int         en_total = 0;
  int         job_base = 0;
  int         tile_idx;
  logic [3:0] arr_ctr = '0;
  always @(posedge clk) begin
    if (channel_out_reset) arr_ctr <= '0;
    else if (channel_out_en) arr_ctr <= arr_ctr + 4'd1;
    if (channel_out_en) en_total <= en_total + 1;
  end
  assign tile_idx = ((en_total - job_base) / ROWS > MAXT - 1) ? MAXT - 1 : (en_total - job_base) / ROWS;
  assign sa_out   = tdata[tile_idx][arr_ctr];

  function automatic void build_exp(input logic md, input int nt);
    logic [31:0] s;
    logic [15:0] h;
    logic [23:0] w;
    for (int r = 0; r < ROWS; r++) begin
      for (int p = 0; p < LANES; p++) begin
        s = '0;
        for (int t = 0; t < nt; t++) begin
          if (md) begin
            h = tdata[t][r][p*16 +: 16];
            s = s + {{16{h[15]}}, h};
          end else if (p < 32) begin
            w = tdata[t][r][p*24 +: 24];
            s = s + {{8{w[23]}}, w};
          end
        end
        expv[r][p] = s;
      end
    end
  endfunction

  function automatic logic [31:0] out_lane(input int r, input int p);
    logic [31:0] e;
    e = expv[r][p];
`ifdef SA_COLLECT_RELU_EN
    if (e[31]) e = '0;
`endif
    return e;
  endfunction

  task automatic fill_rand();
    for (int t = 0; t < MAXT; t++)
      for (int r = 0; r < ROWS; r++)
        for (int w = 0; w < 32; w++)
          tdata[t][r][w*32 +: 32] = $urandom;
  endtask

  // Downstream ready: 0 always ready, 1 pattern 1,0,0,..., 2 random
  int rdy_mode = 0;
  initial begin
    int cyc;
    cyc = 0;
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = (cyc % 3 == 0);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
    end
  end

  // Compare process: every drain beat against the model, stall stability, done timing
  int            beat = 0;
  bit            last_hs = 1'b0;
  bit            stalled = 1'b0;
  logic [2047:0] prev_data;
  logic [3:0]    prev_row;
  always @(negedge clk) begin
    if (!reset) begin
      last_hs = 1'b0;
      stalled = 1'b0;
    end else begin
      if (done || last_hs) chk("done_after_last_beat", done, last_hs);
      if (bus.m_valid) begin
        if (beat < ROWS) begin
          chk("m_row", bus.m_row, beat);
          for (int p = 0; p < LANES; p++)
            chk($sformatf("m_data_r%0d_l%0d", beat, p), bus.m_data[p*AW +: AW], out_lane(beat, p));
        end else begin
          chk("beat_overrun", beat, ROWS - 1);
        end
        if (stalled) chk("stall_hold", (bus.m_data == prev_data) && (bus.m_row == prev_row), 1);
        prev_data = bus.m_data;
        prev_row  = bus.m_row;
        last_hs   = bus.m_ready && (beat == ROWS - 1);
        stalled   = !bus.m_ready;
        if (bus.m_ready) beat++;
      end else begin
        last_hs = 1'b0;
        stalled = 1'b0;
      end
    end
  end

  task automatic run_job(input logic md, input logic [7:0] ci, input int rmode, input bit abort);
    int nt;
    int n;
    int w;
    nt = (ci == 0) ? 1 : int'(ci);
    build_exp(md, nt);
    rdy_mode = rmode;
    beat = 0;
    @(negedge clk);
    job_base = en_total;
    start = 1'b1; mode = md; ci_tiles = ci;
    @(negedge clk);
    start = 1'b0; mode = ~md; ci_tiles = 8'($urandom);
    chk("cor_pulse", channel_out_reset, 1);
    chk("busy_after_start", busy, 1);
    if (rmode == 1) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("cor_single_cycle", channel_out_reset, 0);
    end
    for (int t = 0; t < nt; t++) begin
      w = $urandom_range(0, 3);
      repeat (w) @(negedge clk);
      sa_done = 1'b1;
      @(negedge clk);
      sa_done = 1'b0;
      chk("en_latency", channel_out_en, 1);
      n = 0;
      while (channel_out_en && n < ROWS + 4) begin
        n++;
        if (abort && n == 8) begin
          reset = 1'b0;
          @(negedge clk);
          reset = 1'b1;
          chk("abort_busy", busy, 0);
          chk("abort_en", channel_out_en, 0);
          chk("abort_valid", bus.m_valid, 0);
          chk("abort_cor", channel_out_reset, 1);
          return;
        end
        sa_done = (n == 5);
        @(negedge clk);
      end
      sa_done = 1'b0;
      chk("en_cycles", n, ROWS);
      chk("valid_after_capture", bus.m_valid, (t == nt - 1));
    end
    n = 0;
    while (!done && n < ROWS * 8) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("beats", beat, ROWS);
    chk("en_total", en_total - job_base, nt * ROWS);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    chk("no_cor_after_done", channel_out_reset, 0);
  endtask

  initial begin
    for (int t = 0; t < MAXT; t++)
      for (int r = 0; r < ROWS; r++)
        tdata[t][r] = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cor", channel_out_reset, 1);
    chk("rst_en", channel_out_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_row", bus.m_row, 0);
    chk("rst_data", bus.m_data == '0, 1);
    reset = 1'b1;

    // Mode 0, one tile: every 24-bit lane is -1 + k, garbage above lane 31
    fill_rand();
    for (int k = 0; k < ROWS; k++)
      for (int p = 0; p < 32; p++)
        tdata[0][k][p*24 +: 24] = 24'hFFFFFF + 24'(k);
    run_job(1'b0, 8'd1, 0, 1'b0);
    chk("pin_t1_r0", expv[0][0], 32'hFFFFFFFF);
    chk("pin_t1_r5", expv[5][3], 32'd4);
    chk("pin_t1_hi", expv[5][40], 32'd0);

    // Mode 1, three tiles of 5 in every lane
    for (int t = 0; t < MAXT; t++)
      for (int r = 0; r < ROWS; r++)
        tdata[t][r] = {64{16'h0005}};
    run_job(1'b1, 8'd3, 0, 1'b0);
    chk("pin_t2", expv[9][17], 32'd15);

    // ci_tiles = 0 behaves as one tile
    fill_rand();
    run_job(1'b1, 8'd0, 2, 1'b0);

    // Stalling drain pattern
    fill_rand();
    run_job(1'b1, 8'd2, 1, 1'b0);

    // Reset during capture of row 7, then a clean job
    fill_rand();
    run_job(1'b0, 8'd2, 2, 1'b1);
    run_job(1'b0, 8'd2, 2, 1'b0);

    // Lane sign handling at the output
    fill_rand();
    tdata[0][0][15:0]  = 16'hFFFD;
    tdata[0][0][31:16] = 16'h0003;
    run_job(1'b1, 8'd1, 0, 1'b0);
`ifdef SA_COLLECT_RELU_EN
    chk("pin_t6_neg", out_lane(0, 0), 32'd0);
`else
    chk("pin_t6_neg", out_lane(0, 0), 32'hFFFFFFFD);
`endif
    chk("pin_t6_pos", out_lane(0, 1), 32'd3);

    // Random jobs
    for (int j = 0; j < 4; j++) begin
      fill_rand();
      run_job(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), $urandom_range(0, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
